// File: rtl/flg_operand_fetch_mac_pkg.sv
// flg_operand_fetch_mac_pkg: shared widths, state encoding and width helpers for the operand fetch MAC
package flg_operand_fetch_mac_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;
  function automatic int off_width(input int dw);
    return $clog2(dw) + 1;
  endfunction
  function automatic int prod_width(input int aw, input int ww);
    return aw + ww;
  endfunction
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OFF_WIDTH = off_width(DEF_DATA_WIDTH);
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_ACT_WIDTH = 8;
  localparam int DEF_WEI_WIDTH = 8;
  localparam int DEF_PROD_WIDTH = prod_width(DEF_ACT_WIDTH, DEF_WEI_WIDTH);
  localparam int DEF_PSUM_WIDTH = 24;
endpackage

// File: rtl/flg_mac_acc.sv
// flg_mac_acc: registered signed multiply, wrapping accumulator and pipe-valid tracking
module flg_mac_acc
  import flg_operand_fetch_mac_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int WEI_WIDTH = DEF_WEI_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         rd_en,
  input  logic signed [ACT_WIDTH-1:0]  act,
  input  logic signed [WEI_WIDTH-1:0]  wei,
  output logic [PSUM_WIDTH-1:0]        psum,
  output logic                         busy
);
  localparam int PW = prod_width(ACT_WIDTH, WEI_WIDTH);
  logic data_val, prod_val;
  logic signed [PW-1:0] prod;
  assign busy = rd_en | data_val | prod_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_val <= 1'b0;
      prod_val <= 1'b0;
      prod <= '0;
      psum <= '0;
    end else begin
      data_val <= rd_en;
      prod_val <= data_val;
      if (data_val) prod <= act * wei;
      if (clr) psum <= '0;
      else if (prod_val) psum <= psum + {{(PSUM_WIDTH-PW){prod[PW-1]}}, prod};
    end
endmodule

// File: rtl/flg_operand_fetch_mac.sv
// flg_operand_fetch_mac: turns flag offsets into packed SRAM reads and accumulates one psum per group
module flg_operand_fetch_mac
  import flg_operand_fetch_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OFF_WIDTH = off_width(DATA_WIDTH),
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int WEI_WIDTH = DEF_WEI_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         I_Sta,
  input  logic [ADDR_WIDTH-1:0]        I_ActBase,
  input  logic [ADDR_WIDTH-1:0]        I_WeiBase,
  input  logic                         I_Offset_val,
  input  logic                         I_Match,
  input  logic [OFF_WIDTH-1:0]         I_Offset_Act,
  input  logic [OFF_WIDTH-1:0]         I_Offset_Wei,
  input  logic                         I_fnh,
  output logic                         O_Pipe,
  output logic                         O_ActRdEn,
  output logic [ADDR_WIDTH-1:0]        O_ActRdAddr,
  output logic                         O_WeiRdEn,
  output logic [ADDR_WIDTH-1:0]        O_WeiRdAddr,
  input  logic signed [ACT_WIDTH-1:0]  I_ActRdData,
  input  logic signed [WEI_WIDTH-1:0]  I_WeiRdData,
  output logic [PSUM_WIDTH-1:0]        O_Psum,
  output logic                         O_Psum_val,
  output logic                         O_Busy,
  output logic                         O_Err
);
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] ptr_act, ptr_wei, inc_act, inc_wei;
  logic start, acc, bad, rd, pipe_busy;
  logic [PSUM_WIDTH-1:0] psum;
  assign inc_act = ptr_act + ADDR_WIDTH'(I_Offset_Act);
  assign inc_wei = ptr_wei + ADDR_WIDTH'(I_Offset_Wei);
  assign start = state == IDLE && I_Sta;
  assign acc = state == RUN && I_Offset_val;
  assign bad = I_Match && (I_Offset_Act == '0 || I_Offset_Wei == '0);
  assign rd = acc && I_Match && !bad;
  assign O_Busy = state != IDLE;
  assign O_Pipe = state == RUN;
  assign O_Psum_val = state == OUT;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = I_Sta ? RUN : IDLE;
      RUN:   nxt = (I_fnh && !I_Offset_val) ? DRAIN : RUN;
      DRAIN: nxt = pipe_busy ? DRAIN : OUT;
      OUT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr_act <= '0;
      ptr_wei <= '0;
      O_ActRdEn <= 1'b0;
      O_WeiRdEn <= 1'b0;
      O_ActRdAddr <= '0;
      O_WeiRdAddr <= '0;
      O_Psum <= '0;
      O_Err <= 1'b0;
    end else begin
      state <= nxt;
      O_ActRdEn <= rd;
      O_WeiRdEn <= rd;
      if (rd) begin
        O_ActRdAddr <= inc_act - ADDR_WIDTH'(1);
        O_WeiRdAddr <= inc_wei - ADDR_WIDTH'(1);
      end
      if (start) begin
        ptr_act <= I_ActBase;
        ptr_wei <= I_WeiBase;
      end else if (acc) begin
        ptr_act <= inc_act;
        ptr_wei <= inc_wei;
      end
      if ((acc && bad) || (I_Sta && O_Busy)) O_Err <= 1'b1;
      if (state == DRAIN && !pipe_busy) O_Psum <= psum;
    end
  flg_mac_acc #(
    .ACT_WIDTH(ACT_WIDTH),
    .WEI_WIDTH(WEI_WIDTH),
    .PSUM_WIDTH(PSUM_WIDTH)
  ) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .rd_en(O_ActRdEn),
    .act(I_ActRdData),
    .wei(I_WeiRdData),
    .psum(psum),
    .busy(pipe_busy)
  );
endmodule

// File: tb/tb_flg_operand_fetch_mac.sv
// tb_flg_operand_fetch_mac: table-driven and scoreboard bench for flg_operand_fetch_mac
module tb_flg_operand_fetch_mac;
  logic clk = 1'b0;
  logic rst, sta, oval, match, fnh;
  logic [9:0] act_base, wei_base;
  logic [5:0] off_act, off_wei;
  logic pipe, act_en, wei_en, psum_val, busy, err;
  logic [9:0] act_addr, wei_addr;
  logic signed [7:0] act_rd, wei_rd;
  logic [23:0] psum;
  logic signed [7:0] act_mem [1024];
  logic signed [7:0] wei_mem [1024];
  logic [9:0] qa [$];
  logic [9:0] qw [$];
  logic [23:0] qp [$];
  int cyc = 0;
  int errors = 0, checks = 0, pulses = 0, pulse_cyc = 0;
  typedef struct {
    logic sta;
    logic [9:0] ab, wb;
    logic [5:0] oa, ow;
    logic m;
    logic [9:0] ea, ew;
    logic fin;
    logic [23:0] psum;
    logic [9:0] pa, pw;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (act_en) act_rd <= act_mem[act_addr];
    if (wei_en) wei_rd <= wei_mem[wei_addr];
  end

  flg_operand_fetch_mac dut (
    .clk(clk), .rst(rst), .I_Sta(sta), .I_ActBase(act_base), .I_WeiBase(wei_base),
    .I_Offset_val(oval), .I_Match(match), .I_Offset_Act(off_act), .I_Offset_Wei(off_wei),
    .I_fnh(fnh), .O_Pipe(pipe), .O_ActRdEn(act_en), .O_ActRdAddr(act_addr),
    .O_WeiRdEn(wei_en), .O_WeiRdAddr(wei_addr), .I_ActRdData(act_rd), .I_WeiRdData(wei_rd),
    .O_Psum(psum), .O_Psum_val(psum_val), .O_Busy(busy), .O_Err(err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (act_en || wei_en) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: act_addr %0d wei_addr %0d, none expected", act_addr, wei_addr);
        end else begin
          chk("act_addr", act_addr, qa.pop_front());
          chk("wei_addr", wei_addr, qw.pop_front());
          chk("rd_en_pair", {act_en, wei_en}, 2'b11);
        end
      end
      if (psum_val) begin
        pulses++;
        pulse_cyc = cyc;
        if (qp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: psum %0d, none expected", psum);
        end else chk("psum", psum, qp.pop_front());
      end
    end
  endtask

  task automatic drv(input logic s, input logic v, input logic m, input logic [5:0] oa, input logic [5:0] ow, input logic f);
    @(posedge clk);
    #1;
    sta = s; oval = v; match = m; off_act = oa; off_wei = ow; fnh = f;
  endtask

  task automatic start(input logic [9:0] ab, input logic [9:0] wb);
    act_base = ab;
    wei_base = wb;
    drv(1, 0, 0, 0, 0, 0);
  endtask

  task automatic off(input logic [5:0] oa, input logic [5:0] ow, input logic m, input logic [9:0] ea, input logic [9:0] ew, input logic rd);
    drv(0, 1, m, oa, ow, 0);
    chk("pipe_ready", pipe, 1);
    if (rd) begin
      qa.push_back(ea);
      qw.push_back(ew);
    end
  endtask

  task automatic wait_pulse(input int n);
    int k = 0;
    while (pulses == n && k < 20) begin
      @(posedge clk);
      k++;
    end
    chk("pulse_count", pulses, n + 1);
  endtask

  task automatic fin(input logic [23:0] p);
    int n;
    n = pulses;
    drv(0, 0, 0, 0, 0, 1);
    qp.push_back(p);
    drv(0, 0, 0, 0, 0, 0);
    wait_pulse(n);
    drv(0, 0, 0, 0, 0, 0);
    chk("idle_after_out", busy, 0);
  endtask

  task automatic fill(input logic signed [7:0] a, input logic signed [7:0] w);
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = a;
      wei_mem[i] = w;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last, n;
    tbl[0] = '{1'b1, 10'd0,    10'd0, 6'd2, 6'd1, 1'b1, 10'd1, 10'd0, 1'b0, 24'd0,  10'd0, 10'd0};
    tbl[1] = '{1'b0, 10'd0,    10'd0, 6'd3, 6'd4, 1'b1, 10'd4, 10'd4, 1'b0, 24'd0,  10'd0, 10'd0};
    tbl[2] = '{1'b0, 10'd0,    10'd0, 6'd1, 6'd2, 1'b0, 10'd0, 10'd0, 1'b1, 24'd1,  10'd6, 10'd7};
    tbl[3] = '{1'b1, 10'd1022, 10'd0, 6'd3, 6'd1, 1'b1, 10'd0, 10'd0, 1'b1, 24'd20, 10'd1, 10'd1};
    rst = 1'b1; sta = 0; oval = 0; match = 0; fnh = 0; off_act = 0; off_wei = 0; act_base = 0; wei_base = 0;
    fill(0, 0);
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pipe", pipe, 0);
    chk("rst_rden", {act_en, wei_en}, 0);
    chk("rst_pval", psum_val, 0);
    chk("rst_psum", psum, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    act_mem[1] = 3; act_mem[4] = -2; wei_mem[0] = 5; wei_mem[4] = 7; act_mem[0] = 4;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].sta) start(tbl[i].ab, tbl[i].wb);
      off(tbl[i].oa, tbl[i].ow, tbl[i].m, tbl[i].ea, tbl[i].ew, tbl[i].m);
      if (tbl[i].fin) begin
        fin(tbl[i].psum);
        chk("ptr_act", dut.ptr_act, tbl[i].pa);
        chk("ptr_wei", dut.ptr_wei, tbl[i].pw);
      end
    end
    chk("err_clean", err, 0);
    // 32 back-to-back matches, checks drain latency from last accept to pulse
    fill(1, 1);
    start(0, 0);
    for (int i = 0; i < 32; i++) off(1, 1, 1, 10'(i), 10'(i), 1);
    last = cyc;
    fin(24'd32);
    chk("pulse_latency", pulse_cyc - last, 5);
    fill(-128, -128);
    start(0, 0);
    for (int i = 0; i < 600; i++) off(1, 1, 1, 10'(i), 10'(i), 1);
    fin(24'(600 * 16384));
    // zero offset on a match is illegal: no read, pointers still move
    start(0, 0);
    off(0, 3, 1, 0, 0, 0);
    off(1, 1, 1, 10'd0, 10'd3, 1);
    chk("err_zero_off", err, 1);
    fin(24'd16384);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("err_cleared", err, 0);
    start(5, 5);
    off(1, 1, 1, 10'd5, 10'd5, 1);
    n = pulses;
    drv(0, 0, 0, 0, 0, 1);
    qp.push_back(24'd16384);
    act_base = 0;
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("err_sta_drain", err, 1);
    wait_pulse(n);
    drv(0, 0, 0, 0, 0, 0);
    chk("sta_ignored", busy, 0);
    start(0, 0);
    off(1, 1, 1, 10'd0, 10'd0, 1);
    n = pulses;
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    chk("abort_rden", act_en, 0);
    chk("abort_pval", psum_val, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pipe_valid", dut.pipe_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fnh = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_pulse", pulses, n);
    chk("queues_empty", qa.size() + qp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
